// File: rtl/regfile_wr_ctrl_if.sv
// ============================================================================
// regfile_wr_ctrl_if : WB / MDU request and register-file write-port bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface regfile_wr_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              wb_stall;

  logic              mdu_valid;
  logic              mdu_ready;
  logic [ADDR_W-1:0] mdu_addr;
  logic [DATA_W-1:0] mdu_data;

  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              init_busy;

  modport master (
    output wb_valid, wb_addr, wb_data, mdu_valid, mdu_addr, mdu_data,
    input  wb_stall, mdu_ready, rf_we, rf_waddr, rf_wdata, init_busy
  );

  modport slave (
    input  wb_valid, wb_addr, wb_data, mdu_valid, mdu_addr, mdu_data,
    output wb_stall, mdu_ready, rf_we, rf_waddr, rf_wdata, init_busy
  );
endinterface

`default_nettype wire

// File: rtl/regfile_wr_ctrl.sv
// ============================================================================
// regfile_wr_ctrl : zero-init sweep, then WB/MDU write-port arbitration
// Rev 1.0
// ============================================================================
`default_nettype none

module regfile_wr_ctrl #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int NREGS      = 32,
  parameter int STARVE_MAX = 4
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  regfile_wr_ctrl_if.slave  bus
);

  localparam logic [ADDR_W-1:0] c_last_addr  = ADDR_W'(NREGS - 1);
  localparam logic [3:0]        c_starve_max = 4'(STARVE_MAX);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            state_q,      state_d;
  logic [ADDR_W-1:0] init_cnt_q,   init_cnt_d;
  logic              buf_valid_q,  buf_valid_d;
  logic [ADDR_W-1:0] buf_addr_q,   buf_addr_d;
  logic [DATA_W-1:0] buf_data_q,   buf_data_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic              rf_we_q,      rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q,   rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q,   rf_wdata_d;

  logic w_run;
  logic w_force;
  logic w_buf_win;
  logic w_wb_win;
  logic w_waw_kill;
  logic w_mdu_ready;
  logic w_accept;

  always_comb begin
    w_run       = (state_q == ST_RUN);
    w_force     = buf_valid_q && (starve_cnt_q == c_starve_max);
    w_buf_win   = w_run && buf_valid_q && (w_force || !bus.wb_valid);
    w_wb_win    = w_run && bus.wb_valid && !w_force;
    // WB is younger than anything in the buffer, so a same-address hit retires it
    w_waw_kill  = w_wb_win && buf_valid_q && (buf_addr_q != '0) &&
                  (bus.wb_addr == buf_addr_q);
    w_mdu_ready = w_run && (!buf_valid_q || w_buf_win);
    w_accept    = bus.mdu_valid && w_mdu_ready;
  end

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    buf_valid_d  = buf_valid_q;
    buf_addr_d   = buf_addr_q;
    buf_data_d   = buf_data_q;
    starve_cnt_d = starve_cnt_q;
    rf_we_d      = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;

    case (state_q)
      ST_INIT: begin
        rf_we_d    = 1'b1;
        rf_waddr_d = init_cnt_q;
        rf_wdata_d = '0;
        init_cnt_d = init_cnt_q + ADDR_W'(1);
        if (init_cnt_q == c_last_addr) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        if (w_buf_win) begin
          buf_valid_d  = 1'b0;
          starve_cnt_d = '0;
          if (buf_addr_q != '0) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = buf_addr_q;
            rf_wdata_d = buf_data_q;
          end
        end else if (w_wb_win) begin
          if (bus.wb_addr != '0) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = bus.wb_addr;
            rf_wdata_d = bus.wb_data;
          end
          if (w_waw_kill) begin
            buf_valid_d  = 1'b0;
            starve_cnt_d = '0;
          end else if (buf_valid_q && (starve_cnt_q != c_starve_max)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
        end
        // x0 results never reach the port but are still consumed
        if (w_accept) begin
          buf_valid_d = 1'b1;
          buf_addr_d  = bus.mdu_addr;
          buf_data_d  = bus.mdu_data;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      init_cnt_q   <= '0;
      buf_valid_q  <= 1'b0;
      buf_addr_q   <= '0;
      buf_data_q   <= '0;
      starve_cnt_q <= '0;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      buf_valid_q  <= buf_valid_d;
      buf_addr_q   <= buf_addr_d;
      buf_data_q   <= buf_data_d;
      starve_cnt_q <= starve_cnt_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
    end
  end

  assign bus.wb_stall  = bus.wb_valid && !w_wb_win;
  assign bus.mdu_ready = w_mdu_ready;
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.init_busy = (state_q == ST_INIT);

endmodule

`default_nettype wire

// File: tb/tb_regfile_wr_ctrl.sv
// ============================================================================
// tb_regfile_wr_ctrl : directed bench with a queue-based reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_regfile_wr_ctrl;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 5;
  localparam int NREGS      = 32;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst_n;

  regfile_wr_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_wr_ctrl #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .NREGS     (NREGS),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model: pending writes as a queue -------------
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t              m_buf[$];
  bit                m_init;
  int                m_idx;
  int                m_starve;
  bit                m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;

  always @(negedge clk) begin : compare
    bit   frc, btake, exp_stall, exp_ready;
    ent_t e;
    if (!rst_n) begin
      m_buf.delete();
      m_init   = 1'b1;
      m_idx    = 0;
      m_starve = 0;
      m_we     = 1'b0;
      m_addr   = '0;
      m_data   = '0;
      chk("m_rst_we",    bus.rf_we,     0);
      chk("m_rst_addr",  bus.rf_waddr,  0);
      chk("m_rst_data",  bus.rf_wdata,  0);
      chk("m_rst_busy",  bus.init_busy, 1);
      chk("m_rst_ready", bus.mdu_ready, 0);
    end else begin
      if (m_init) begin
        frc       = 1'b0;
        btake     = 1'b0;
        exp_stall = bus.wb_valid;
        exp_ready = 1'b0;
      end else begin
        frc       = (m_buf.size() != 0) && (m_starve == STARVE_MAX);
        btake     = (m_buf.size() != 0) && (frc || !bus.wb_valid);
        exp_stall = bus.wb_valid && frc;
        exp_ready = (m_buf.size() == 0) || btake;
      end
      chk("m_stall", bus.wb_stall,  exp_stall);
      chk("m_ready", bus.mdu_ready, exp_ready);
      chk("m_busy",  bus.init_busy, m_init);
      chk("m_we",    bus.rf_we,     m_we);
      if (m_we) begin
        chk("m_addr", bus.rf_waddr, m_addr);
        chk("m_data", bus.rf_wdata, m_data);
      end
      // next registered outputs and state
      if (m_init) begin
        m_we   = 1'b1;
        m_addr = ADDR_W'(m_idx);
        m_data = '0;
        m_idx++;
        if (m_idx == NREGS) m_init = 1'b0;
      end else if (btake) begin
        e        = m_buf.pop_front();
        m_starve = 0;
        m_we     = (e.addr != 0);
        if (m_we) begin
          m_addr = e.addr;
          m_data = e.data;
        end
      end else if (bus.wb_valid) begin
        m_we = (bus.wb_addr != 0);
        if (m_we) begin
          m_addr = bus.wb_addr;
          m_data = bus.wb_data;
        end
        if (m_buf.size() != 0) begin
          if (bus.wb_addr != 0 && m_buf[0].addr == bus.wb_addr) begin
            m_buf.delete();
            m_starve = 0;
          end else if (m_starve < STARVE_MAX) begin
            m_starve++;
          end
        end
      end else begin
        m_we = 1'b0;
      end
      if (bus.mdu_valid && exp_ready) m_buf.push_back({bus.mdu_addr, bus.mdu_data});
    end
  end

  // ---------------- directed stimulus with literal expectations ------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    bus.wb_valid  = 1'b0;
    bus.wb_addr   = '0;
    bus.wb_data   = '0;
    bus.mdu_valid = 1'b0;
    bus.mdu_addr  = '0;
    bus.mdu_data  = '0;
  endtask

  task automatic sweep(input bit noisy);
    for (int i = 0; i < NREGS; i++) begin
      bus.wb_valid  = noisy && (i < 3);
      bus.wb_addr   = 5'd1;
      bus.wb_data   = 32'hBAD0_0000 + i;
      bus.mdu_valid = noisy && (i < 3);
      bus.mdu_addr  = 5'd2;
      bus.mdu_data  = 32'hBAD1_0000 + i;
      if (noisy && i < 3) begin
        #1;
        chk("init_stall", bus.wb_stall,  1);
        chk("init_ready", bus.mdu_ready, 0);
      end
      cyc();
      chk("sweep_we",   bus.rf_we,     1);
      chk("sweep_addr", bus.rf_waddr,  i);
      chk("sweep_data", bus.rf_wdata,  0);
      chk("sweep_busy", bus.init_busy, (i < NREGS - 1) ? 1 : 0);
    end
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) cyc();
    chk("rst_we",    bus.rf_we,     0);
    chk("rst_addr",  bus.rf_waddr,  0);
    chk("rst_busy",  bus.init_busy, 1);
    chk("rst_ready", bus.mdu_ready, 0);
    rst_n = 1'b1;
    sweep(1'b1);

    cyc();
    chk("run_idle_we", bus.rf_we, 0);

    // single WB write
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'hDEAD_BEEF;
    #1 chk("wb_stall0", bus.wb_stall, 0);
    cyc();
    bus.wb_valid = 1'b0;
    chk("wb_we",   bus.rf_we,    1);
    chk("wb_addr", bus.rf_waddr, 5);
    chk("wb_data", bus.rf_wdata, 32'hDEAD_BEEF);

    // MDU through buffer, two-cycle latency
    bus.mdu_valid = 1'b1; bus.mdu_addr = 5'd7; bus.mdu_data = 32'h12;
    #1 chk("mdu_ready_empty", bus.mdu_ready, 1);
    cyc();
    bus.mdu_valid = 1'b0;
    chk("mdu_no_passthru", bus.rf_we, 0);
    #1 chk("mdu_ready_drain", bus.mdu_ready, 1);
    cyc();
    chk("mdu_we",   bus.rf_we,    1);
    chk("mdu_addr", bus.rf_waddr, 7);
    chk("mdu_data", bus.rf_wdata, 32'h12);

    // starvation guard
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'h33;
    bus.mdu_valid = 1'b1; bus.mdu_addr = 5'd9; bus.mdu_data = 32'h99;
    cyc();
    bus.mdu_valid = 1'b0;
    chk("stv_first_addr", bus.rf_waddr, 3);
    for (int k = 0; k < STARVE_MAX; k++) begin
      #1 chk("stv_wb_stall", bus.wb_stall, 0);
      cyc();
      chk("stv_wb_addr", bus.rf_waddr, 3);
    end
    #1 chk("stv_force_stall", bus.wb_stall, 1);
    cyc();
    chk("stv_buf_addr", bus.rf_waddr, 9);
    chk("stv_buf_data", bus.rf_wdata, 32'h99);
    #1 chk("stv_held_stall", bus.wb_stall, 0);
    cyc();
    chk("stv_held_addr", bus.rf_waddr, 3);
    bus.wb_valid = 1'b0;
    cyc();

    // x0 writes are consumed silently
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'hFF;
    cyc();
    bus.wb_valid = 1'b0;
    chk("x0_wb_we", bus.rf_we, 0);
    bus.mdu_valid = 1'b1; bus.mdu_addr = 5'd0; bus.mdu_data = 32'h55;
    #1 chk("x0_mdu_ready", bus.mdu_ready, 1);
    cyc();
    bus.mdu_valid = 1'b0;
    #1 chk("x0_mdu_ready2", bus.mdu_ready, 1);
    cyc();
    chk("x0_mdu_we", bus.rf_we, 0);
    cyc();

    // WAW kill
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd2; bus.wb_data = 32'h22;
    bus.mdu_valid = 1'b1; bus.mdu_addr = 5'd4; bus.mdu_data = 32'h44;
    cyc();
    bus.mdu_valid = 1'b0;
    chk("waw_pre_addr", bus.rf_waddr, 2);
    bus.wb_addr = 5'd4; bus.wb_data = 32'h4444;
    #1 chk("waw_ready_full", bus.mdu_ready, 0);
    cyc();
    bus.wb_valid = 1'b0;
    chk("waw_we",   bus.rf_we,    1);
    chk("waw_addr", bus.rf_waddr, 4);
    chk("waw_data", bus.rf_wdata, 32'h4444);
    #1 chk("waw_ready_empty", bus.mdu_ready, 1);
    cyc();
    chk("waw_no_stale", bus.rf_we, 0);

    // mixed deterministic traffic, checked by the model alone
    for (int i = 0; i < 48; i++) begin
      bus.wb_valid  = (i % 4) != 3;
      bus.wb_addr   = 5'((i * 5) % 8);
      bus.wb_data   = 32'h1000 + i;
      bus.mdu_valid = (i % 3) != 1;
      bus.mdu_addr  = 5'((i * 3) % 8);
      bus.mdu_data  = 32'h2000 + i;
      cyc();
    end
    idle_inputs();
    repeat (4) cyc();

    // asynchronous reset with a buffered entry in flight
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd6; bus.wb_data = 32'h66;
    bus.mdu_valid = 1'b1; bus.mdu_addr = 5'd9; bus.mdu_data = 32'h99;
    cyc();
    bus.mdu_valid = 1'b0;
    chk("pre_rst_addr", bus.rf_waddr, 6);
    cyc();
    chk("pre_rst_we", bus.rf_we, 1);
    rst_n = 1'b0;
    idle_inputs();
    #1;
    chk("arst_we",    bus.rf_we,     0);
    chk("arst_addr",  bus.rf_waddr,  0);
    chk("arst_data",  bus.rf_wdata,  0);
    chk("arst_busy",  bus.init_busy, 1);
    chk("arst_ready", bus.mdu_ready, 0);
    repeat (2) cyc();
    rst_n = 1'b1;
    sweep(1'b0);
    cyc();
    chk("post_rst_we",    bus.rf_we,     0);
    chk("post_rst_ready", bus.mdu_ready, 1);
    cyc();
    chk("post_rst_we2", bus.rf_we, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
